uart_txrx: RTL and testbench
============================

# uart_txrx

Full-duplex 8N1 UART engine: one transmitter and one receiver sharing a clock and reset, with no FIFOs. It sits between the SoC memory-mapped IO decode and the board pins. The CPU writes a byte to start a transmission and polls `o_Tx_Active`, `o_Rx_DV` and `o_Rx_Byte` through the IO status/data words. Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.

## Interface
- `CLKS_PER_BIT`, default 234: clock cycles per bit (27 MHz / 115200 baud); legal range ≥ 4.
- `i_Clock`  in  1  system clock; everything is rising-edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `i_Tx_DV`  in  1  transmit request, one-cycle strobe.
- `i_Tx_Byte`  in  8  byte to send; sampled on the cycle `i_Tx_DV` is accepted.
- `o_Tx_Active`  out  1  high while a frame is being transmitted.
- `o_Tx_Serial`  out  1  serial output line; idles high.
- `o_Tx_Done`  out  1  one-cycle pulse when the stop bit completes.
- `i_Rx_Serial`  in  1  asynchronous serial input line.
- `o_Rx_DV`  out  1  received-byte-valid indication.
- `o_Rx_Byte`  out  8  last correctly framed byte received.

## Operation
- **TX FSM:** IDLE → START → DATA → STOP → IDLE. Each bit lasts exactly `CLKS_PER_BIT` cycles; 10 bits per frame.
- **TX accept:** in IDLE, `i_Tx_DV`=1 latches `i_Tx_Byte`, asserts `o_Tx_Active` and drives `o_Tx_Serial`=0. `i_Tx_DV` is ignored while `o_Tx_Active`=1; requests made then are dropped, with no queuing.
- **TX data:** bits 0..7 in order, followed by a stop bit of 1.
- **TX completion:** at the end of the stop bit, `o_Tx_Active`→0 and `o_Tx_Done` pulses for 1 cycle. A new request is accepted on that same cycle, giving back-to-back frames.
- **RX input sync:** `i_Rx_Serial` passes through a 2-flop synchronizer before any use.
- **RX FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized 0 enters START.
  - START: at count `(CLKS_PER_BIT-1)/2` the line is re-sampled. If it is still 0, enter DATA; if it is 1, treat it as a glitch and return to IDLE with no output.
  - DATA: samples every `CLKS_PER_BIT` cycles into an internal shift register, LSB first.
  - STOP: sample taken one bit-time after the last data bit.
- **RX result:**
  - Stop bit = 1: `o_Rx_Byte` ← shift register and `o_Rx_DV` pulses for 1 cycle.
  - Stop bit = 0 (framing error): the byte is discarded, `o_Rx_Byte` is unchanged and `o_Rx_DV` stays 0.
  - In both cases the FSM returns to IDLE immediately after the stop sample.
- **Partial data:** `o_Rx_Byte` never shows partial data; it changes only on a valid frame.
- **Independence:** TX and RX are fully independent. Simultaneous activity is legal.

## Timing
- **Reset values:** `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, `o_Rx_DV`=0, `o_Rx_Byte`=0, both FSMs IDLE, all counters 0.
- **Reset mid-frame:** the line goes high immediately and asynchronously. The partial RX frame is discarded.
- **TX latency:** `i_Tx_DV` is sampled at edge k. `o_Tx_Serial` falls and `o_Tx_Active` rises after edge k. The stop bit ends at edge k+10·`CLKS_PER_BIT`, where `o_Tx_Active` falls and `o_Tx_Done` rises for one cycle.
- **RX latency:** `o_Rx_DV` rises about 2 (synchronizer) + `(CLKS_PER_BIT-1)/2` + 9·`CLKS_PER_BIT` cycles after the start-bit falling edge.
- **RX rearm:** the receiver accepts a new start edge on the cycle after the stop sample. This tolerates senders whose stop bit is up to ½ bit short.
- **Counter width:** bit counters are `$clog2(CLKS_PER_BIT)` bits wide and wrap to 0 at `CLKS_PER_BIT-1`.

## Configuration
- `UART_RX_STICKY_DV_EN`:
  - Defined: `o_Rx_DV` is set on a valid frame and held high until the next start bit is accepted (START confirmation) or reset. This suits CPU polling of the status bit.
  - Undefined: `o_Rx_DV` is a single-cycle pulse.

## Structure
- Shared package `uart_pkg`:
  - TX and RX state enums (IDLE/START/DATA/STOP).
  - Default `CLKS_PER_BIT` constant.
  - Frame constants: 8 data bits, start level 0, stop level 1.
- One natural sub-module, `uart_sync2`: 2-flop synchronizer with reset value 1, used on `i_Rx_Serial`.
- TX and RX are kept as separate process groups inside `uart_txrx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
- **Reset:** hold `resetn`=0 → `o_Tx_Serial`=1, all other outputs 0. Deassert with no stimulus → outputs are unchanged for 200 cycles.
- **TX 0xA5:** pulse `i_Tx_DV` with `i_Tx_Byte`=0xA5 → line is 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles. `o_Tx_Active` is high for 80 cycles, then `o_Tx_Done` pulses once.
- **TX busy:** a second `i_Tx_DV` (0x3C) mid-frame → ignored, only 0xA5 is sent. A request on the `o_Tx_Done` cycle → a back-to-back frame.
- **RX loopback:** drive `o_Tx_Serial` into `i_Rx_Serial` and send 0x5A, then 0xFF → `o_Rx_Byte`=0x5A with `o_Rx_DV` asserted, then 0xFF.
- **RX glitch and framing error:** a 2-cycle low pulse → no `o_Rx_DV`. A frame for 0x11 with stop bit 0 → no `o_Rx_DV` and `o_Rx_Byte` unchanged.
- **Sticky macro:** with `UART_RX_STICKY_DV_EN` defined, receive 0x42 → `o_Rx_DV` stays 1 until the next start bit is confirmed. Without the macro, the pulse is exactly 1 cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART engine: state encodings, frame
// constants and the default bit period (27 MHz / 115200 baud).
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 234;

  // Frame format: one start bit, DATA_BITS data bits LSB first, one stop bit.
  localparam int   DATA_BITS   = 8;
  localparam int   IDX_W       = $clog2(DATA_BITS);
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_txrx_if.sv
// CPU-side bundle of the UART engine plus the two FSM states for observation.
//
// Transmit handshake: i_Tx_DV is a one-cycle valid carrying i_Tx_Byte. The
// implied ready is !o_Tx_Active; a valid presented while not ready is dropped,
// never held or queued. o_Tx_Done marks the cycle the engine becomes ready
// again, and a valid on that very cycle is accepted. On the receive side
// o_Rx_DV is a valid with no ready: the byte in o_Rx_Byte stays put until the
// next correctly framed byte overwrites it.
interface uart_txrx_if;
  import uart_pkg::*;

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  tx_state_t            dbg_tx_state;
  rx_state_t            dbg_rx_state;

  // CPU / pin side.
  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte,
    input  dbg_tx_state, dbg_rx_state
  );

  // UART engine side.
  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte,
    output dbg_tx_state, dbg_rx_state
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous serial line. Both flops reset to
// 1 so an idle line never looks like a start bit coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw line through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART engine, one transmitter and one receiver, no FIFOs.
// TX and RX are independent process groups sharing only clock and reset.
// Build option: UART_RX_STICKY_DV_EN holds o_Rx_DV high from a good frame
// until the next start bit is confirmed; without it o_Rx_DV is a 1-cycle pulse.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        i_Clock,
  input  logic        resetn,
  uart_txrx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  // Mid-bit point of the start bit; every later sample is a whole bit after it.
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  // ---------------------------------------------------------------- TX ----
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [IDX_W-1:0]     tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_serial, tx_serial_n;
  logic                 tx_done, tx_done_n;

  // TX state register; the line itself is a flop so the pin never glitches.
  always_ff @(posedge i_Clock or negedge resetn) begin
    if (!resetn) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_serial <= STOP_LEVEL;
      tx_done   <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_idx    <= tx_idx_n;
      tx_shift  <= tx_shift_n;
      tx_serial <= tx_serial_n;
      tx_done   <= tx_done_n;
    end
  end

  // TX next state: the value loaded into tx_serial is the level of the bit
  // that starts on the coming edge, so bit boundaries line up with state.
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_idx_n    = tx_idx;
    tx_shift_n  = tx_shift;
    tx_serial_n = STOP_LEVEL;
    tx_done_n   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (bus.i_Tx_DV) begin
          tx_shift_n  = bus.i_Tx_Byte;
          tx_cnt_n    = '0;
          tx_serial_n = START_LEVEL;
          tx_state_n  = TX_START;
        end
      end
      TX_START: begin
        tx_serial_n = START_LEVEL;
        if (tx_cnt == CNT_MAX) begin
          tx_cnt_n    = '0;
          tx_idx_n    = '0;
          tx_serial_n = tx_shift[0];
          tx_state_n  = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        tx_serial_n = tx_shift[0];
        if (tx_cnt == CNT_MAX) begin
          tx_cnt_n = '0;
          if (tx_idx == LAST_IDX) begin
            tx_serial_n = STOP_LEVEL;
            tx_state_n  = TX_STOP;
          end else begin
            tx_idx_n    = tx_idx + IDX_W'(1);
            tx_shift_n  = {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_serial_n = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_MAX) begin
          tx_cnt_n   = '0;
          tx_done_n  = 1'b1;
          tx_state_n = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign bus.o_Tx_Serial  = tx_serial;
  assign bus.o_Tx_Active  = (tx_state != TX_IDLE);
  assign bus.o_Tx_Done    = tx_done;
  assign bus.dbg_tx_state = tx_state;

  // ---------------------------------------------------------------- RX ----
  logic                 rx_s;
  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [IDX_W-1:0]     rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic [DATA_BITS-1:0] rx_byte, rx_byte_n;
  logic                 rx_dv, rx_dv_n;

  uart_sync2 u_rx_sync (
    .clk    (i_Clock),
    .resetn (resetn),
    .d      (bus.i_Rx_Serial),
    .q      (rx_s)
  );

  // RX state register; a reset mid-frame simply drops the partial byte.
  always_ff @(posedge i_Clock or negedge resetn) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_dv    <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_byte  <= rx_byte_n;
      rx_dv    <= rx_dv_n;
    end
  end

  // RX next state: confirm the start bit at mid-bit, then sample one bit
  // period apart; the byte is published only when the stop bit reads high.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_byte_n  = rx_byte;
`ifdef UART_RX_STICKY_DV_EN
    rx_dv_n    = rx_dv;
`else
    rx_dv_n    = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s == START_LEVEL) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n = '0;
          if (rx_s == START_LEVEL) begin
            rx_idx_n   = '0;
            rx_state_n = RX_DATA;
`ifdef UART_RX_STICKY_DV_EN
            rx_dv_n    = 1'b0;
`endif
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_MAX) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == LAST_IDX) rx_state_n = RX_STOP;
          else                    rx_idx_n   = rx_idx + IDX_W'(1);
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_MAX) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_s == STOP_LEVEL) begin
            rx_byte_n = rx_shift;
            rx_dv_n   = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign bus.o_Rx_DV      = rx_dv;
  assign bus.o_Rx_Byte    = rx_byte;
  assign bus.dbg_rx_state = rx_state;

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx at 8 clocks per bit. TX is checked cycle by cycle
// against the frame {stop, byte, start} laid out bit by bit; RX is checked by
// a scoreboard queue of bytes whose frames carried a good stop bit.
module tb_uart_txrx;

  localparam int C = 8;

  logic clk     = 1'b0;
  logic resetn  = 1'b0;
  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_b;
  logic       dv_prev  = 1'b0;
  int         dv_width = 0;
`ifdef UART_RX_STICKY_DV_EN
  bit         sticky_probe = 1'b0;
`endif

  uart_txrx_if bus();

  uart_txrx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock (clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.i_Rx_Serial = loop_en ? bus.o_Tx_Serial : rx_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tx_obs();
    return {29'd0, bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done};
  endfunction

  function automatic logic [31:0] all_obs();
    return {20'd0, bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Rx_DV, bus.o_Rx_Byte};
  endfunction

  // Entered at a negedge with i_Tx_DV=1 / i_Tx_Byte=b already driven.
  task automatic tx_frame(input logic [7:0] b, input bit poke, input bit chain, input logic [7:0] nb);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    bus.i_Tx_DV = 1'b0;
    for (int j = 0; j < 10 * C; j++) begin
      check("tx_line", tx_obs(), {29'd0, fr[j / C], 1'b1, 1'b0});
      if (poke && j == 3 * C + 2) begin
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = 8'h3C;
      end else begin
        bus.i_Tx_DV = 1'b0;
      end
      @(negedge clk);
    end
    check("tx_done", tx_obs(), 32'd5);
    if (chain) begin
      bus.i_Tx_DV   = 1'b1;
      bus.i_Tx_Byte = nb;
    end else begin
      @(negedge clk);
      check("tx_idle", tx_obs(), 32'd4);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_val, input int stop_len);
    logic [9:0] fr;
    fr = {stop_val, b, 1'b0};
    if (stop_val) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      for (int k = 0; k < ((i == 9) ? stop_len : C); k++) begin
        @(negedge clk);
`ifdef UART_RX_STICKY_DV_EN
        if (sticky_probe && i == 0 && k == 5) check("sticky_hold", {31'd0, bus.o_Rx_DV}, 32'd1);
        if (sticky_probe && i == 0 && k == 6) check("sticky_clear", {31'd0, bus.o_Rx_DV}, 32'd0);
`endif
      end
    end
    rx_drv = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 * C && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  // RX scoreboard: every new o_Rx_DV must match the oldest expected byte.
  always @(negedge clk) begin
    if (bus.o_Rx_DV && !dv_prev) begin
      if (exp_q.size() == 0) begin
        check("rx_dv_unexpected", {31'd0, bus.o_Rx_DV}, 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        check("rx_byte", {24'd0, bus.o_Rx_Byte}, {24'd0, exp_b});
        last_good = exp_b;
      end
    end
`ifndef UART_RX_STICKY_DV_EN
    if (!bus.o_Rx_DV && dv_prev) check("rx_dv_width", dv_width, 1);
`endif
    if (bus.o_Rx_DV) dv_width = dv_prev ? dv_width + 1 : 1;
    dv_prev = bus.o_Rx_DV;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] nb;
    bus.i_Tx_DV   = 1'b0;
    bus.i_Tx_Byte = 8'h00;

    // Reset and quiet idle.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_obs(), 32'h800);
    resetn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_after_reset", all_obs(), 32'h800);
    end

    // TX 0xA5 with a dropped mid-frame request, then a request on the done cycle.
    nb = 8'($urandom);
    bus.i_Tx_DV   = 1'b1;
    bus.i_Tx_Byte = 8'hA5;
    tx_frame(8'hA5, 1'b1, 1'b1, nb);
    tx_frame(nb, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      bus.i_Tx_DV   = 1'b1;
      bus.i_Tx_Byte = b;
      tx_frame(b, 1'b0, 1'b0, 8'h00);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Loopback, back-to-back frames, TX and RX active together.
    loop_en = 1'b1;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hFF);
    bus.i_Tx_DV   = 1'b1;
    bus.i_Tx_Byte = 8'h5A;
    tx_frame(8'h5A, 1'b0, 1'b1, 8'hFF);
    tx_frame(8'hFF, 1'b0, 1'b0, 8'h00);
    drain("loopback_drain");
    check("loopback_last", {24'd0, bus.o_Rx_Byte}, 32'hFF);
    loop_en = 1'b0;

    // Random direct RX frames, stop bit as short as 3/4 bit, minimal gaps.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1, $urandom_range(6, C));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain("rx_random_drain");

    // Two-cycle glitch.
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * C) @(negedge clk);
    check("glitch_hold", {24'd0, bus.o_Rx_Byte}, {24'd0, last_good});

    // Framing error on 0x11.
    rx_send(8'h11, 1'b0, C);
    repeat (4 * C) @(negedge clk);
    check("frame_err_hold", {24'd0, bus.o_Rx_Byte}, {24'd0, last_good});
    check("frame_err_dv", {31'd0, bus.o_Rx_DV}, 32'd0);

    // Receive 0x42 and look at how long o_Rx_DV lasts.
    rx_send(8'h42, 1'b1, C);
    repeat (30) @(negedge clk);
`ifdef UART_RX_STICKY_DV_EN
    check("sticky_level", {31'd0, bus.o_Rx_DV}, 32'd1);
    sticky_probe = 1'b1;
    rx_send(8'h99, 1'b1, C);
    sticky_probe = 1'b0;
`else
    check("pulse_gone", {31'd0, bus.o_Rx_DV}, 32'd0);
    rx_send(8'($urandom), 1'b1, C);
`endif
    drain("final_rx_drain");
    check("rx_byte_latest", {24'd0, bus.o_Rx_Byte}, {24'd0, last_good});

    // Reset in the middle of a TX and an RX frame.
    bus.i_Tx_DV   = 1'b1;
    bus.i_Tx_Byte = 8'h00;
    @(negedge clk);
    bus.i_Tx_DV = 1'b0;
    rx_drv = 1'b0;
    repeat (3 * C) @(negedge clk);
    check("mid_frame_line_low", {31'd0, bus.o_Tx_Serial}, 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("reset_async", {28'd0, bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Rx_DV}, 32'h8);
    check("reset_rx_byte", {24'd0, bus.o_Rx_Byte}, 32'd0);
    last_good = 8'h00;
    rx_drv = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("post_reset_idle", all_obs(), 32'h800);
    check("post_reset_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
